// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between an operand requester and the serial adder.
// A start is taken only on an edge where ready=1; a and b are sampled on that edge.
interface serial_add_ctrl_if #(parameter int W = 8);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  modport master (output start, a, b, input ready, busy, done, sum, cout);
  modport slave  (input start, a, b, output ready, busy, done, sum, cout);
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial W-bit adder: one full-add slice (two half-adder cells) reused LSB
// first, one bit per clock, with a start/ready front end and a one-cycle done pulse.
module serial_add_ctrl #(
  parameter int W = 8
) (
  input  logic              clk,
  input  logic              rst,
  serial_add_ctrl_if.slave  bus,
  output logic [1:0]        state_dbg
);

  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic [W-1:0]  s_sh;
  logic          carry;
  logic [CW-1:0] cnt;
  logic [W-1:0]  sum_q;
  logic          cout_q;

  logic          p;
  logic          g1;
  logic          s;
  logic          g2;
  logic          carry_next;
  logic [W-1:0]  s_sh_next;
  logic          last;

  // Two half-adder cells form the shared full-add slice.
  assign p          = a_sh[0] ^ b_sh[0];
  assign g1         = a_sh[0] & b_sh[0];
  assign s          = p ^ carry;
  assign g2         = p & carry;
  assign carry_next = g1 | g2;
  assign s_sh_next  = (s_sh >> 1) | (W'(s) << (W - 1));
  assign last       = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last)      state_next = DONE;
      DONE:                   state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Results are captured from the shift-in value of the final RUN edge and
  // held until the next completion; an accept does not clear them.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      s_sh   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            s_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          s_sh  <= s_sh_next;
          carry <= carry_next;
          cnt   <= cnt + CW'(1);
          if (last) begin
            sum_q  <= s_sh_next;
            cout_q <= carry_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready = (state == IDLE);
  assign bus.busy  = (state == RUN);
  assign bus.done  = (state == DONE);
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
  assign state_dbg = state;

endmodule
